// File: rtl/regfile_sb_pkg.sv
// Shared types for the integer register file and its pending-write scoreboard.
package regfile_sb_pkg;
    localparam int XLEN_DEF  = 64;
    localparam int NREG_DEF  = 32;
    localparam int CNT_W_DEF = 2;
    localparam int REG_AW    = $clog2(NREG_DEF);

    typedef logic [XLEN_DEF-1:0]  word_t;
    typedef logic [REG_AW-1:0]    creg_addr_t;
    typedef logic [CNT_W_DEF-1:0] sb_cnt_t;

    // Writeback bundle as the W stage presents it.
    typedef struct packed {
        logic       wvalid;
        creg_addr_t wa;
        word_t      wd;
        logic       wretire;
    } wb_port_t;
endpackage

// File: rtl/regfile_sb_counter_bank.sv
// Per-register in-flight writer counters: issue gating, retire, busy flags.
// REGFILE_BYPASS_EN: a retiring last writer clears busy in the same cycle.
module regfile_sb_counter_bank #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_dst,
    output logic          iss_ready,
    input  logic          ret_valid,
    input  logic [AW-1:0] ret_addr,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          busy1,
    output logic          busy2
);
    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0]            inc_v;
    logic [NREG-1:0]            dec_v;
    logic                       inc_ok;
    logic                       dec_ok;

    assign iss_ready = (iss_dst == '0) || (cnt[iss_dst] != '1);
    assign inc_ok    = iss_valid && iss_ready && (iss_dst != '0);
    assign dec_ok    = ret_valid && (ret_addr != '0);

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        if (inc_ok) inc_v[iss_dst]  = 1'b1;
        if (dec_ok) dec_v[ret_addr] = 1'b1;
    end

    // Issue and retire on the same register cancel; an empty counter never wraps down.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (inc_v[r] && !dec_v[r])
                    cnt[r] <= cnt[r] + CNT_W'(1);
                else if (dec_v[r] && !inc_v[r] && cnt[r] != '0)
                    cnt[r] <= cnt[r] - CNT_W'(1);
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic hit1;
    logic hit2;
    assign hit1  = dec_ok && (ret_addr == ra1);
    assign hit2  = dec_ok && (ret_addr == ra2);
    assign busy1 = (ra1 != '0) && ((cnt[ra1] - CNT_W'(hit1)) != '0);
    assign busy2 = (ra2 != '0) && ((cnt[ra2] - CNT_W'(hit2)) != '0);
`else
    assign busy1 = (ra1 != '0) && (cnt[ra1] != '0);
    assign busy2 = (ra2 != '0) && (cnt[ra2] != '0);
`endif

    for (genvar r = 1; r < NREG; r++) begin : g_uflow
        a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
            !(dec_v[r] && !inc_v[r] && cnt[r] == '0));
    end
endmodule

// File: rtl/regfile_sb.sv
// Architectural register file (x0 = 0) with two combinational read ports and a
// pending-write scoreboard. REGFILE_BYPASS_EN enables write-through on reads.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [$clog2(NREG)-1:0] ra1,
    input  logic [$clog2(NREG)-1:0] ra2,
    output logic [XLEN-1:0]         rd1,
    output logic [XLEN-1:0]         rd2,
    output logic                    busy1,
    output logic                    busy2,
    input  logic                    iss_valid,
    input  logic [$clog2(NREG)-1:0] iss_dst,
    output logic                    iss_ready,
    input  logic                    wvalid,
    input  logic [$clog2(NREG)-1:0] wa,
    input  logic [XLEN-1:0]         wd,
    input  logic                    wretire
);
    localparam int AW = $clog2(NREG);

    wb_port_t                   wb;
    logic [NREG-1:0][XLEN-1:0]  rf;
    logic                       wr_en;

    assign wb    = '{wvalid: wvalid, wa: wa, wd: wd, wretire: wretire};
    assign wr_en = wb.wvalid && (wb.wa != '0);

    always_ff @(posedge clk) begin
        if (!reset)
            rf <= '0;
        else if (wr_en)
            rf[wb.wa] <= wb.wd;
    end

    always_comb begin
        rd1 = rf[ra1];
        rd2 = rf[ra2];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wb.wa == ra1) rd1 = wb.wd;
        if (wr_en && wb.wa == ra2) rd2 = wb.wd;
`endif
        // x0 reads zero regardless of storage or bypass.
        if (ra1 == '0) rd1 = '0;
        if (ra2 == '0) rd2 = '0;
    end

    regfile_sb_counter_bank #(
        .NREG  (NREG),
        .CNT_W (CNT_W),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_dst   (iss_dst),
        .iss_ready (iss_ready),
        .ret_valid (wb.wvalid && wb.wretire),
        .ret_addr  (wb.wa),
        .ra1       (ra1),
        .ra2       (ra2),
        .busy1     (busy1),
        .busy2     (busy2)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: per-cycle model compare plus literal checkpoints.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ra1, ra2, iss_dst, wa;
    logic [63:0] rd1, rd2, wd;
    logic        busy1, busy2, iss_valid, iss_ready, wvalid, wretire;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    logic [63:0] mreg [32];
    int          mcnt [32];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2), .iss_valid(iss_valid), .iss_dst(iss_dst),
        .iss_ready(iss_ready), .wvalid(wvalid), .wa(wa), .wd(wd), .wretire(wretire)
    );

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: outputs derived from architectural contents and writer counts.
    function automatic logic [63:0] m_rd(input logic [4:0] a);
        if (a == 0) return 64'd0;
        if (BYP && wvalid && wa == a) return wd;
        return mreg[a];
    endfunction

    function automatic bit m_busy(input logic [4:0] a);
        int n;
        if (a == 0) return 1'b0;
        n = mcnt[a];
        if (BYP && wvalid && wretire && wa == a) n = n - 1;
        return n > 0;
    endfunction

    function automatic bit m_ready();
        return (iss_dst == 0) || (mcnt[iss_dst] < 3);
    endfunction

    always @(posedge clk) begin
        bit inc, dec;
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                mreg[i] <= 64'd0;
                mcnt[i] <= 0;
            end
        end else begin
            inc = iss_valid && m_ready() && iss_dst != 0;
            dec = wvalid && wretire && wa != 0;
            if (wvalid && wa != 0) mreg[wa] <= wd;
            if (!(inc && dec && iss_dst == wa)) begin
                if (inc) mcnt[iss_dst] <= mcnt[iss_dst] + 1;
                if (dec && mcnt[wa] > 0) mcnt[wa] <= mcnt[wa] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            cmp("model_rd1", rd1, m_rd(ra1));
            cmp("model_rd2", rd2, m_rd(ra2));
            cmp("model_busy1", 64'(busy1), 64'(m_busy(ra1)));
            cmp("model_busy2", 64'(busy2), 64'(m_busy(ra2)));
            cmp("model_iss_ready", 64'(iss_ready), 64'(m_ready()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_dst = 5'd0;
        wvalid = 1'b0; wa = 5'd0; wd = 64'd0; wretire = 1'b0;
    endtask

    initial begin
        idle();
        ra1 = 5'd0; ra2 = 5'd0;
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        check_en = 1'b1;
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(31 - a); iss_dst = 5'(a);
            #1;
            cmp("rst_rd1", rd1, 64'd0);
            cmp("rst_rd2", rd2, 64'd0);
            cmp("rst_busy1", 64'(busy1), 64'd0);
            cmp("rst_ready", 64'(iss_ready), 64'd1);
        end
        iss_dst = 5'd0;

        // Write then read, and x0 write ignored
        step();
        wvalid = 1'b1; wa = 5'd5; wd = 64'hDEAD_BEEF_0000_0001; ra1 = 5'd5;
        #1 cmp("wr_same_cycle", rd1, BYP ? 64'hDEAD_BEEF_0000_0001 : 64'd0);
        step(); idle(); ra1 = 5'd5;
        #1 cmp("wr_read", rd1, 64'hDEAD_BEEF_0000_0001);
        wvalid = 1'b1; wa = 5'd0; wd = 64'd1; ra2 = 5'd0;
        #1 cmp("x0_wr_same", rd2, 64'd0);
        step(); idle(); ra2 = 5'd0;
        #1 cmp("x0_read", rd2, 64'd0);
        cmp("x0_busy", 64'(busy2), 64'd0);

        // Same-cycle write/read of x7
        wvalid = 1'b1; wa = 5'd7; wd = 64'd100;
        step(); idle();
        wvalid = 1'b1; wa = 5'd7; wd = 64'd42; ra1 = 5'd7;
        #1 cmp("byp_same", rd1, BYP ? 64'd42 : 64'd100);
        step(); idle(); ra1 = 5'd7;
        #1 cmp("byp_next", rd1, 64'd42);

        // Saturate x3's counter
        iss_valid = 1'b1; iss_dst = 5'd3; ra1 = 5'd3; ra2 = 5'd3;
        #1 cmp("sb_ready0", 64'(iss_ready), 64'd1);
        cmp("sb_busy0", 64'(busy1), 64'd0);
        step();
        cmp("sb_busy1", 64'(busy1), 64'd1);
        cmp("sb_ready1", 64'(iss_ready), 64'd1);
        step(); step();
        cmp("sb_sat_ready", 64'(iss_ready), 64'd0);
        cmp("sb_sat_busy", 64'(busy1), 64'd1);
        step(); idle(); iss_dst = 5'd3;
        #1 cmp("sb_hold_no_inc", 64'(iss_ready), 64'd0);
        wvalid = 1'b1; wretire = 1'b1; wa = 5'd3; wd = 64'd5;
        #1 cmp("sb_retire_busy", 64'(busy1), 64'd1);
        step(); idle(); iss_dst = 5'd3;
        #1 cmp("sb_retire_ready", 64'(iss_ready), 64'd1);
        cmp("sb_retire_still_busy", 64'(busy2), 64'd1);

        // Last writer retiring on x9
        iss_valid = 1'b1; iss_dst = 5'd9; ra1 = 5'd9;
        step(); idle();
        iss_valid = 1'b1; iss_dst = 5'd9;
        wvalid = 1'b1; wretire = 1'b1; wa = 5'd9; wd = 64'd99;
        #1 cmp("lr_sim_busy", 64'(busy1), BYP ? 64'd0 : 64'd1);
        step(); idle();
        #1 cmp("lr_sim_keeps", 64'(busy1), 64'd1);
        wvalid = 1'b1; wretire = 1'b1; wa = 5'd9; wd = 64'd98;
        #1 cmp("lr_retire_busy", 64'(busy1), BYP ? 64'd0 : 64'd1);
        step(); idle();
        #1 cmp("lr_after", 64'(busy1), 64'd0);
        cmp("lr_data", rd1, 64'd98);

        // Issue to x0 has no scoreboard effect
        iss_valid = 1'b1; iss_dst = 5'd0; ra1 = 5'd0;
        #1 cmp("x0_iss_ready", 64'(iss_ready), 64'd1);
        step(); idle();
        #1 cmp("x0_iss_busy", 64'(busy1), 64'd0);

        // Reset while x4 has two writers outstanding
        wvalid = 1'b1; wa = 5'd4; wd = 64'd77; iss_valid = 1'b1; iss_dst = 5'd4;
        step(); step(); idle(); ra1 = 5'd4; iss_dst = 5'd4;
        #1 cmp("mf_busy", 64'(busy1), 64'd1);
        cmp("mf_data", rd1, 64'd77);
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1 cmp("mf_rst_rd", rd1, 64'd0);
        cmp("mf_rst_busy", 64'(busy1), 64'd0);
        cmp("mf_rst_ready", 64'(iss_ready), 64'd1);
        cmp("mf_rst_x3_busy", 64'(busy2), 64'd0);
        cmp("mf_rst_x3_rd", rd2, 64'd0);
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Architectural integer register file with a pending-write scoreboard. Serves the decode stage's two read ports (ra1/ra2 → rd1/rd2) and takes the writeback port from the W stage.
- The scoreboard counts in-flight writers per register. Decode uses the busy flags to stall when no forwarding source can yet supply the operand.
- Sits beside decode; writeback drives the write port.

Parameters:
- NREG, 32, number of architectural registers; x0 is hardwired to zero.
- XLEN, 64, register width; equals the width of word_t.
- CNT_W, 2, width of each per-register pending counter; at most 2^CNT_W−1 writers in flight per register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; state clears on a rising edge while reset==0.
- ra1  in  5  read address, port 1 (creg_addr_t).
- ra2  in  5  read address, port 2 (creg_addr_t).
- rd1  out  XLEN  read data, port 1 (word_t).
- rd2  out  XLEN  read data, port 2 (word_t).
- busy1  out  1  ra1 has a pending writer after this cycle's retire.
- busy2  out  1  ra2 has a pending writer after this cycle's retire.
- iss_valid  in  1  an instruction with a destination register leaves decode this cycle.
- iss_dst  in  5  destination of the issuing instruction.
- iss_ready  out  1  iss_dst counter is not saturated, so issue is allowed.
- wvalid  in  1  writeback write enable.
- wa  in  5  write address.
- wd  in  XLEN  write data.
- wretire  in  1  this write retires one scoreboard entry; 0 means a plain write with no scoreboard effect (debug/initialisation).

Behaviour:
- Reset (reset==0 at a clock edge): all registers become 0 and all counters become 0. Outputs then read rd1=rd2=0, busy1=busy2=0, iss_ready=1.
- Reset mid-operation discards all pending counts; in-flight writers are assumed flushed by the pipeline.
- Reads are combinational, with zero-cycle latency.
  - ra==0 → data 0 and busy 0, always.
- Write: on the clock edge, if wvalid && wa!=0, reg[wa] ← wd. A write with wa==0 is ignored.
- Scoreboard: cnt[r] is CNT_W bits wide. Per clock edge:
  - inc = iss_valid && iss_ready && iss_dst!=0
  - dec = wvalid && wretire && wa!=0
  - same register with both inc and dec → net unchanged.
  - dec when cnt==0 is a protocol error: counter stays at 0; assertion under simulation.
- iss_ready = (iss_dst==0) || cnt[iss_dst] != all-ones. iss_valid while iss_ready==0 causes no increment; decode must hold.
- busy_i = (ra_i!=0) && (cnt[ra_i] − retire_hit_i) != 0, where retire_hit_i = dec && wa==ra_i. A retiring last writer therefore does not stall.
- Issue in the same cycle does not affect busy; it is visible from the next cycle.
- Wrap-around: counters never wrap. Saturation is blocked via iss_ready; underflow is clamped.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-through bypass. If wvalid && wa!=0 && wa==ra_i, rd_i = wd in the same cycle.
- Undefined: rd_i returns the old reg[ra_i] until the edge.
  - busy_i then ignores retire_hit_i, so a retiring register stays busy for one more cycle.
- Scoreboard logic is otherwise identical in both builds.

Decomposition:
- Package common: word_t, creg_addr_t, XLEN-dependent constants.
- Package pipes: sb_cnt_t (CNT_W-bit counter) and a wb_port_t struct {wvalid, wa, wd, wretire}, so W-stage output binds as one bundle.
- One natural sub-module: sb_counter_bank (NREG counters; inc/dec/ready/busy logic), kept separate from the storage array.

Test Plan:
- Reset: hold reset=0 two cycles, then read all 32 addresses → rd=0, busy=0, iss_ready=1.
- Write/read: wvalid=1, wa=5, wd=64'hDEAD_BEEF_0000_0001; next cycle ra1=5 → rd1=64'hDEAD_BEEF_0000_0001. Write wa=0, wd=1 → ra2=0 reads 0.
- Bypass: same-cycle wa=ra1=7, wd=42.
  - With REGFILE_BYPASS_EN: rd1=42 that cycle.
  - Without: rd1=old value; 42 appears next cycle.
- Scoreboard: issue dst=3 three times (cnt=3) → iss_ready=0 for dst=3, busy1=1 for ra1=3. Retire wa=3 once → iss_ready=1 next cycle, busy stays 1.
- Last retire: cnt[9]=1, retire wa=9 with ra1=9.
  - Bypass build: busy1=0 that cycle.
  - Non-bypass build: busy1=1 that cycle, 0 the next.
  - Simultaneous iss dst=9 + retire wa=9 → cnt remains 1.
- Reset mid-flight: cnt[4]=2, assert reset=0 one cycle → cnt[4]=0, reg[4]=0, busy=0.
